// File: rtl/comb_lock_pkg.sv
// Shared types and constants for the three-button combination lock.
package comb_lock_pkg;

  localparam int unsigned BTN_W   = 3;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S0      = 4'd0,
    S1      = 4'd1,
    S2      = 4'd2,
    S3      = 4'd3,
    S4      = 4'd4,
    S5      = 4'd5,
    S6      = 4'd6,
    S7      = 4'd7,
    OPEN    = 4'd8,
    LOCKOUT = 4'd9
  } state_t;

  localparam logic [BTN_W-1:0] BTN_NONE = 3'b000;
  localparam logic [BTN_W-1:0] BTN_A    = 3'b001;
  localparam logic [BTN_W-1:0] BTN_B    = 3'b010;
  localparam logic [BTN_W-1:0] BTN_C    = 3'b100;

  function automatic logic is_onehot3(input logic [BTN_W-1:0] v);
    return (v == BTN_A) || (v == BTN_B) || (v == BTN_C);
  endfunction

endpackage

// File: rtl/comb_lock_input.sv
// Button front end: 2-flop synchronizer, previous-sample register and press decode.
module comb_lock_input
  import comb_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] comb,
  output logic [BTN_W-1:0] btn_c,
  output logic             press_c,
  output logic             illegal_c,
  output logic             idle_c
);

  logic [BTN_W-1:0] sync1_q, sync1_d;
  logic [BTN_W-1:0] sync2_q, sync2_d;
  logic [BTN_W-1:0] prev_q,  prev_d;

  always_comb begin
    sync1_d = comb;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BTN_NONE;
      sync2_q <= BTN_NONE;
      prev_q  <= BTN_NONE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // A press is a single button rising out of the all-released state.
  always_comb begin
    btn_c     = sync2_q;
    idle_c    = (sync2_q == BTN_NONE);
    illegal_c = !idle_c && !is_onehot3(sync2_q);
    press_c   = is_onehot3(sync2_q) && (prev_q == BTN_NONE);
  end

endmodule

// File: rtl/comb_lock.sv
// Combination lock FSM: matches NUM_DIGITS one-hot presses, with timed lockout and optional relock.
module comb_lock
  import comb_lock_pkg::*;
#(
  parameter int unsigned              NUM_DIGITS     = 4,
  parameter logic [3*NUM_DIGITS-1:0]  CODE           = {BTN_A, BTN_B, BTN_C, BTN_A},
  parameter int unsigned              LOCKOUT_CYCLES = 16,
  parameter int unsigned              RELOCK_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] comb,
  output logic       unlock
);

  localparam int unsigned CNT_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                     : RELOCK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("comb_lock: NUM_DIGITS must be in 2..8");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("comb_lock: LOCKOUT_CYCLES must be >= 1");
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_code_chk
    if (!is_onehot3(CODE[3*i +: 3])) begin : g_bad_digit
      $error("comb_lock: CODE digit is not one-hot");
    end
  end

  logic [BTN_W-1:0] btn_c;
  logic             press_c;
  logic             illegal_c;
  logic             idle_c;

  comb_lock_input u_input (
    .clk       (clk),
    .rst_n     (rst_n),
    .comb      (comb),
    .btn_c     (btn_c),
    .press_c   (press_c),
    .illegal_c (illegal_c),
    .idle_c    (idle_c)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             unlock_q, unlock_d;

  logic [2:0]       idx_c;
  logic [BTN_W-1:0] digit_c;
  logic             last_c;

  // Expected button for the current digit position.
  always_comb begin
    idx_c   = state_q[2:0];
    digit_c = BTN_NONE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_c == 3'(i)) digit_c = CODE[3*i +: 3];
    end
    last_c  = (idx_c == 3'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S0;
      cnt_q    <= '0;
      unlock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      unlock_q <= unlock_d;
    end
  end

  // One counter serves both LOCKOUT and OPEN; the two never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OPEN: begin
        if (illegal_c) begin
          state_d = LOCKOUT;
          cnt_d   = CNT_W'(LOCKOUT_CYCLES);
        end else if (press_c) begin
          state_d = S0;
        end else if (RELOCK_CYCLES > 0) begin
          if (cnt_q <= CNT_W'(1)) state_d = S0;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      LOCKOUT: begin
        if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
        else if (idle_c) state_d = S0;
      end
      default: begin
        if (illegal_c) begin
          state_d = LOCKOUT;
          cnt_d   = CNT_W'(LOCKOUT_CYCLES);
        end else if (press_c) begin
          if (btn_c == digit_c) begin
            if (last_c) begin
              state_d = OPEN;
              cnt_d   = CNT_W'(RELOCK_CYCLES);
            end else begin
              state_d = state_t'(state_q + 4'd1);
            end
          end else if (btn_c == CODE[2:0]) begin
            state_d = S1;
          end else begin
            state_d = S0;
          end
        end
      end
    endcase
  end

  always_comb begin
    unlock_d = (state_d == OPEN);
  end

  assign unlock = unlock_q;

endmodule

// File: tb/tb_comb_lock.sv
// Directed self-checking bench for comb_lock (default instance plus a relock instance).
module tb_comb_lock;
  import comb_lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] comb;
  logic       unlock;
  logic       unlock_r;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  comb_lock dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .comb   (comb),
    .unlock (unlock)
  );

  comb_lock #(.RELOCK_CYCLES(8)) dut_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .comb   (comb),
    .unlock (unlock_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    comb = b;
    tick(hold);
    comb = BTN_NONE;
    tick(4);
  endtask

  task automatic do_reset();
    comb  = BTN_NONE;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    // Reset with a button held: everything stays clear.
    comb  = BTN_A;
    rst_n = 1'b0;
    tick(4);
    chk("rst_unlock", 32'(unlock), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S0));
    chk("rst_sync2", 32'(dut.u_input.sync2_q), 32'd0);
    comb  = BTN_NONE;
    rst_n = 1'b1;
    tick(10);
    chk("idle_unlock", 32'(unlock), 32'd0);
    chk("idle_state", 32'(dut.state_q), 32'(S0));

    // Correct code A,C,B,A with exact latency on the final press.
    press(BTN_A, 5);
    press(BTN_C, 8);
    press(BTN_B, 6);
    comb = BTN_A;
    tick(2);
    chk("lat_edge2", 32'(unlock), 32'd0);
    tick(1);
    chk("lat_edge3", 32'(unlock), 32'd1);
    tick(6);
    comb = BTN_NONE;
    tick(4);
    chk("open_hold", 32'(unlock), 32'd1);
    chk("open_state", 32'(dut.state_q), 32'(OPEN));
    press(BTN_B, 5);
    chk("close_b_unlock", 32'(unlock), 32'd0);
    chk("close_b_state", 32'(dut.state_q), 32'(S0));

    // Overlap: A,A,C,B,A opens; a press of A from OPEN is consumed.
    press(BTN_A, 5); press(BTN_A, 7); press(BTN_C, 5); press(BTN_B, 9); press(BTN_A, 5);
    chk("overlap_open", 32'(unlock), 32'd1);
    press(BTN_A, 5);
    chk("open_press_a_state", 32'(dut.state_q), 32'(S0));
    chk("open_press_a_unlock", 32'(unlock), 32'd0);

    // Wrong digit: A,B,C,B,A ends in S1 without opening.
    do_reset();
    press(BTN_A, 5); press(BTN_B, 5); press(BTN_C, 5); press(BTN_B, 5); press(BTN_A, 5);
    chk("wrong_unlock", 32'(unlock), 32'd0);
    chk("wrong_state", 32'(dut.state_q), 32'(S1));

    // Long hold counts once.
    do_reset();
    press(BTN_A, 12); press(BTN_C, 6); press(BTN_B, 6); press(BTN_A, 6);
    chk("hold_open", 32'(unlock), 32'd1);

    // Switching A->C without a release is not a C event.
    do_reset();
    comb = BTN_A;
    tick(4);
    comb = BTN_C;
    tick(4);
    comb = BTN_NONE;
    tick(4);
    chk("switch_state", 32'(dut.state_q), 32'(S1));
    press(BTN_B, 5); press(BTN_A, 5);
    chk("switch_unlock", 32'(unlock), 32'd0);
    chk("switch_state2", 32'(dut.state_q), 32'(S1));

    // Illegal input: lockout of 16 counted cycles, no reload, exit on idle.
    do_reset();
    press(BTN_A, 5); press(BTN_C, 5);
    comb = 3'b011;
    tick(3);
    chk("lock_enter", 32'(dut.state_q), 32'(LOCKOUT));
    chk("lock_unlock", 32'(unlock), 32'd0);
    comb = BTN_NONE; tick(2);
    comb = 3'b111;   tick(2);
    comb = BTN_NONE; tick(2);
    comb = BTN_A;    tick(3);
    comb = BTN_NONE; tick(7);
    chk("lock_last", 32'(dut.state_q), 32'(LOCKOUT));
    tick(1);
    chk("lock_exit", 32'(dut.state_q), 32'(S0));
    press(BTN_A, 5); press(BTN_C, 5); press(BTN_B, 5); press(BTN_A, 5);
    chk("after_lock_open", 32'(unlock), 32'd1);

    // Asynchronous reset mid-sequence and while open.
    do_reset();
    press(BTN_A, 5); press(BTN_C, 5); press(BTN_B, 5);
    chk("mid_s3", 32'(dut.state_q), 32'(S3));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(dut.state_q), 32'(S0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    press(BTN_A, 5); press(BTN_C, 5); press(BTN_B, 5); press(BTN_A, 5);
    chk("pre_rst_open", 32'(unlock), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_unlock", 32'(unlock), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Auto-relock after 8 cycles on the relock instance only.
    press(BTN_A, 5); press(BTN_C, 5); press(BTN_B, 5);
    comb = BTN_A;
    tick(3);
    chk("relock_rise", 32'(unlock_r), 32'd1);
    tick(4);
    comb = BTN_NONE;
    tick(3);
    chk("relock_cycle7", 32'(unlock_r), 32'd1);
    tick(1);
    chk("relock_drop", 32'(unlock_r), 32'd0);
    chk("relock_state", 32'(dut_r.state_q), 32'(S0));
    tick(10);
    chk("no_relock_default", 32'(unlock), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
